// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
//
// Responder side of the single-cycle core's data-memory port. Decodes each
// word access into a RAM region (starting at byte 0) or a 256-byte MMIO page,
// and returns load data combinationally in the same cycle.
//
// MMIO page (word offsets from MMIO_BASE):
//   0x00 CYCLES  RO  free-running cycle counter (only with CYCLE_COUNTER_EN)
//   0x04 GPIO    RW  bits[15:0] drive gpio_out
//   0x08 EVSTAT  RO  {overflow@16, count@14:8, full@1, not_empty@0}
//   0x0C EVDATA  RO  head byte of the event FIFO; a load (MemRead) pops it
//   0x10 EVCTRL  WO  bit0 clears overflow, bit1 flushes the FIFO
//
// Optional feature macro: CYCLE_COUNTER_EN
//   defined   -> the CYCLES counter exists
//   undefined -> no counter flops, offset 0x00 reads 0
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   MemWrite   store strobe
//   MemRead    load strobe; qualifies the EVDATA pop side effect
//   Addr       byte address (Addr[1:0] ignored)
//   WriteData  store data
//   ReadData   load data, combinational from Addr and current state
//   ev_valid   producer has an event byte
//   ev_data    event byte
//   ev_ready   responder accepts an event this cycle
//   gpio_out   GPIO output register
//
// Event handshake: a byte transfers on a rising edge where ev_valid and
// ev_ready are both high. ev_ready depends only on FIFO fullness and reset,
// never on ev_valid. ev_valid while full drops the byte and sets overflow.
// -----------------------------------------------------------------------------
module data_bus_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        ev_valid,
    input  logic [7:0]  ev_data,
    output logic        ev_ready,
    output logic [15:0] gpio_out
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    localparam logic [5:0] SEL_CYCLES = 6'd0;
    localparam logic [5:0] SEL_GPIO   = 6'd1;
    localparam logic [5:0] SEL_EVSTAT = 6'd2;
    localparam logic [5:0] SEL_EVDATA = 6'd3;
    localparam logic [5:0] SEL_EVCTRL = 6'd4;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [5:0]    reg_sel;

    assign ram_hit  = (Addr < RAM_BYTES);
    assign ram_idx  = Addr[AW+1:2];
    // RAM takes priority should MMIO_BASE ever be placed inside the RAM range.
    assign mmio_hit = !ram_hit && (Addr[31:8] == MMIO_BASE[31:8]);
    assign reg_sel  = Addr[7:2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   ram_q  [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [15:0]   gpio_q,   gpio_d;
    logic          ovf_q,    ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic ctrl_wr;
    logic flush;
    logic ovf_clr;
    logic ovf_set;
    logic gpio_wr;
    logic ram_wr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign ev_ready   = !fifo_full && !reset;
    assign gpio_out   = gpio_q;

    // Every side effect is gated by reset so accesses presented during
    // reset are ignored even for state that reset does not clear (RAM).
    assign push    = ev_valid && ev_ready;
    assign pop     = MemRead && mmio_hit && (reg_sel == SEL_EVDATA) && !fifo_empty && !reset;
    assign ctrl_wr = MemWrite && mmio_hit && (reg_sel == SEL_EVCTRL) && !reset;
    assign flush   = ctrl_wr && WriteData[1];
    assign ovf_clr = ctrl_wr && WriteData[0];
    assign ovf_set = ev_valid && fifo_full && !reset;
    assign gpio_wr = MemWrite && mmio_hit && (reg_sel == SEL_GPIO) && !reset;
    assign ram_wr  = MemWrite && ram_hit && !reset;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        gpio_d   = gpio_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (gpio_wr) begin
            gpio_d = WriteData[15:0];
        end

        // A dropped byte in the same cycle as a clear keeps overflow set.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        // Flush overrides any simultaneous push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            gpio_q   <= gpio_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram_q[ram_idx] <= WriteData;
        end
        if (push && !flush) begin
            fifo_q[wr_ptr_q] <= ev_data;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;

    assign cycles_d = cycles_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] evstat;
    logic [31:0] cycles_rd;

    assign evstat = {15'b0, ovf_q, 1'b0, 7'(count_q), 6'b0, fifo_full, !fifo_empty};

`ifdef CYCLE_COUNTER_EN
    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = 32'd0;
`endif

    always_comb begin
        ReadData = 32'd0;
        if (ram_hit) begin
            ReadData = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                SEL_CYCLES: ReadData = cycles_rd;
                SEL_GPIO:   ReadData = {16'b0, gpio_q};
                SEL_EVSTAT: ReadData = evstat;
                SEL_EVDATA: ReadData = fifo_empty ? 32'd0 : {24'b0, fifo_q[rd_ptr_q]};
                default:    ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

    localparam int          RAM_WORDS  = 1024;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'h0001_0000;
    localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] A_CYC  = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_GPIO = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_STAT = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_DATA = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_CTRL = MMIO_BASE + 32'h10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        ev_valid;
    logic [7:0]  ev_data;
    logic        ev_ready;
    logic [15:0] gpio_out;

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .gpio_out (gpio_out)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_ram   [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [7:0]  m_fifo  [$];
    logic        m_ovf;
    logic [15:0] m_gpio;
    logic [31:0] m_cyc;

    // Scoreboard entry: {rd_known, ev_ready, gpio_out[15:0], ReadData[31:0]}
    logic [49:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    function automatic bit is_ram(input logic [31:0] a);
        return a < RAM_BYTES;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return !is_ram(a) && (a[31:8] == MMIO_BASE[31:8]);
    endfunction

    function automatic int reg_of(input logic [31:0] a);
        return int'(a[7:0]) / 4;
    endfunction

    // Returns {known, data} for a load from address a in the current model state.
    function automatic logic [32:0] model_read(input logic [31:0] a);
        int n;
        n = m_fifo.size();
        if (is_ram(a)) begin
            return {m_known[int'(a >> 2)], m_ram[int'(a >> 2)]};
        end
        if (!is_mmio(a)) return {1'b1, 32'd0};
        case (reg_of(a))
`ifdef CYCLE_COUNTER_EN
            0: return {1'b1, m_cyc};
`endif
            1: return {1'b1, 16'd0, m_gpio};
            2: return {1'b1, (32'(m_ovf) << 16) + (32'(n) << 8)
                             + ((n == FIFO_DEPTH) ? 32'd2 : 32'd0) + ((n > 0) ? 32'd1 : 32'd0)};
            3: return (n > 0) ? {1'b1, 24'd0, m_fifo[0]} : {1'b1, 32'd0};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // ---------------- driver ----------------
    // One bus cycle: present inputs, queue the expected outputs, advance the
    // model across the rising edge. When 'forced' is set the ReadData
    // expectation is the constant fexp instead of the model's value.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic evv, input logic [7:0] evd,
                        input bit chk, input bit forced, input logic [31:0] fexp);
        logic [32:0] r;
        logic        rdy;
        bit          full;
        bit          mm;
        int          ro;
        reset     = rst;
        MemWrite  = we;
        MemRead   = re;
        Addr      = a;
        WriteData = wd;
        ev_valid  = evv;
        ev_data   = evd;
        r   = forced ? {1'b1, fexp} : model_read(a);
        rdy = !rst && (m_fifo.size() < FIFO_DEPTH);
        if (chk) exp_q.push_back({r[32], rdy, m_gpio, r[31:0]});
        @(posedge clk);
        if (rst) begin
            m_cyc  = 32'd0;
            m_gpio = 16'd0;
            m_ovf  = 1'b0;
            m_fifo.delete();
        end else begin
            full = (m_fifo.size() == FIFO_DEPTH);
            mm   = is_mmio(a);
            ro   = reg_of(a);
            m_cyc = m_cyc + 32'd1;
            if (we && is_ram(a)) begin
                m_ram[int'(a >> 2)]   = wd;
                m_known[int'(a >> 2)] = 1'b1;
            end
            if (we && mm && ro == 1) m_gpio = wd[15:0];
            if (we && mm && ro == 4 && wd[1]) begin
                m_fifo.delete();
            end else begin
                if (re && mm && ro == 3 && m_fifo.size() > 0) void'(m_fifo.pop_front());
                if (evv && !full) m_fifo.push_back(evd);
            end
            if (evv && full) m_ovf = 1'b1;
            else if (we && mm && ro == 4 && wd[0]) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0002_0000, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, 0, a, d, 0, 0, 1, 0, 0);
    endtask

    task automatic push(input logic [7:0] d);
        step(0, 0, 0, A_STAT, 0, 1, d, 1, 0, 0);
    endtask

    task automatic probe(input logic re, input logic [31:0] a, input logic [31:0] e);
        step(0, 0, re, a, 0, 0, 0, 1, 1, e);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s addr=%h got=%h exp=%h t=%0t", name, Addr, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [49:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[49]) check("read_data", ReadData, e[31:0]);
            check("ev_ready", 32'(ev_ready), 32'(e[48]));
            check("gpio_out", 32'(gpio_out), 32'(e[47:32]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        reset = 1'b1; MemWrite = 0; MemRead = 0; Addr = 0; WriteData = 0;
        ev_valid = 0; ev_data = 0;
        m_ovf = 0; m_gpio = 0; m_cyc = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, A_STAT, 0, 1, 8'h5A, 1, 0, 0);   // ev_ready low while in reset

        // reset state and cycle counter
        idle(5);
`ifdef CYCLE_COUNTER_EN
        probe(0, A_CYC, 32'd5);
`else
        probe(0, A_CYC, 32'd0);
`endif
        probe(0, A_STAT, 32'd0);

        // RAM: read-old-on-same-cycle-write, low address bits ignored, unmapped
        wr(32'h10, 32'h1234_5678);
        step(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h1234_5678);
        probe(0, 32'h10, 32'hDEAD_BEEF);
        probe(0, 32'h13, 32'hDEAD_BEEF);
        probe(0, 32'h0002_0000, 32'd0);
        wr(RAM_BYTES, 32'hCAFE_F00D);
        probe(0, RAM_BYTES, 32'd0);
        wr(RAM_BYTES - 4, 32'h0BAD_CAFE);
        probe(0, RAM_BYTES - 4, 32'h0BAD_CAFE);

        // GPIO and unlisted/write-only MMIO offsets
        wr(A_GPIO, 32'h0003_ABCD);
        probe(0, A_GPIO, 32'h0000_ABCD);
        probe(0, A_CTRL, 32'd0);
        probe(0, MMIO_BASE + 32'h14, 32'd0);
        probe(0, MMIO_BASE + 32'h104, 32'd0);

        // FIFO basic push/pop, non-popping read, pop while empty
        push(8'h11);
        push(8'h22);
        probe(0, A_STAT, 32'h0000_0201);
        probe(1, A_DATA, 32'h11);
        probe(1, A_DATA, 32'h22);
        probe(0, A_STAT, 32'd0);
        push(8'h44);
        probe(0, A_DATA, 32'h44);
        probe(0, A_DATA, 32'h44);
        probe(0, A_STAT, 32'h0000_0101);
        probe(1, A_DATA, 32'h44);
        probe(1, A_DATA, 32'd0);
        probe(0, A_STAT, 32'd0);

        // Fill past full, overflow sticky, clear vs set, flush vs push
        for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
        probe(0, A_STAT, 32'h0001_0803);
        step(0, 1, 0, A_CTRL, 32'd1, 1, 8'hEE, 1, 0, 0);
        probe(0, A_STAT, 32'h0001_0803);
        wr(A_CTRL, 32'd1);
        probe(0, A_STAT, 32'h0000_0803);
        probe(1, A_DATA, 32'hA0);
        step(0, 1, 0, A_CTRL, 32'd2, 1, 8'h55, 1, 0, 0);
        probe(0, A_STAT, 32'd0);
        probe(0, A_DATA, 32'd0);

        // Simultaneous push and pop with one entry
        push(8'h77);
        step(0, 0, 1, A_DATA, 0, 1, 8'h33, 1, 1, 32'h77);
        probe(0, A_STAT, 32'h0000_0101);
        probe(0, A_DATA, 32'h33);

        // Reset mid-operation with entries queued and a store presented
        push(8'h01);
        push(8'h02);
        wr(A_GPIO, 32'h0000_1234);
        step(1, 1, 1, A_GPIO, 32'h0000_5555, 1, 8'h99, 1, 0, 0);
        probe(0, A_STAT, 32'd0);
        probe(0, A_GPIO, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = $urandom_range(0, 63);
                2:       a = ($urandom_range(0, 1) != 0 ? RAM_BYTES - 4 : RAM_BYTES) + $urandom_range(0, 3);
                3, 4, 5: a = MMIO_BASE + $urandom_range(0, 23);
                6:       a = MMIO_BASE + 32'h100 + $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            we = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            if (is_mmio(a) && reg_of(a) == 4 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
            step($urandom_range(0, 299) == 0, we, 1'($urandom_range(0, 1)), a, wd,
                 $urandom_range(0, 2) != 0, 8'($urandom), 1, 0, 0);
        end

        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
